// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by uart_tx and the future uart_rx.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..DIV-1 while enabled and pulses bit_tick on the last count.
module uart_baud_gen #(
  parameter int unsigned DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // clear wins over en so a new frame always starts its first bit at count 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = en && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per accepted TxD_start, LSB first, optional parity, 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy
);

  localparam int unsigned DIV      = calc_div(CLK_HZ, BAUD);
  localparam parity_e     PAR_MODE = parity_e'(PARITY[1:0]);
  localparam logic        LAST_STOP = (STOP_BITS == 2);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx: DIV=%0d derived from CLK_HZ/BAUD must be >= 2", DIV);
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY=%0d must be 0, 1 or 2", PARITY);
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       parity_q, parity_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       accept;
  logic       bit_tick;

  assign accept = TxD_start && !busy_q;

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .en      (state_q != IDLE),
    .bit_tick(bit_tick)
  );

  // txd_d is the level of the bit being entered, so the line is a pure register output.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    txd_d      = txd_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d    = TxD_data;
          parity_d   = (PAR_MODE == PAR_ODD) ? ~^TxD_data : ^TxD_data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        if (bit_tick) begin
          txd_d   = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == 3'd7) begin
            if (PAR_MODE != PAR_NONE) begin
              txd_d   = parity_q;
              state_d = uart_pkg::PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = STOP;
            end
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bit_tick) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  assign TxD      = txd_q;
  assign TxD_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) at DIV=10.
module tb_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       txd_start = 1'b0;
  logic [7:0] txd_data = 8'h00;
  logic [3:0] txd;
  logic [3:0] busy;
  logic [1:0] sel = 2'd0;
  logic       cur_txd;
  logic       cur_busy;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int run_len = 0;

  logic exp_bits[$];
  logic got_bits[$];
  int   exp_busy[$];
  int   busy_runs[$];
  int   frame_start[$];

  always #5 clk = ~clk;

  uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .TxD_start(txd_start), .TxD_data(txd_data),
    .TxD(txd[0]), .TxD_busy(busy[0]));
  uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .TxD_start(txd_start), .TxD_data(txd_data),
    .TxD(txd[1]), .TxD_busy(busy[1]));
  uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .TxD_start(txd_start), .TxD_data(txd_data),
    .TxD(txd[2]), .TxD_busy(busy[2]));
  uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .TxD_start(txd_start), .TxD_data(txd_data),
    .TxD(txd[3]), .TxD_busy(busy[3]));

  assign cur_txd  = txd[sel];
  assign cur_busy = busy[sel];

  always @(posedge clk) cyc <= cyc + 1;

  // Length of each completed busy pulse of the selected instance; a reset discards a partial run.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len <= 0;
    end else if (cur_busy === 1'b1) begin
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      busy_runs.push_back(run_len);
      run_len <= 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_frame(input logic [7:0] d, input int par, input int stops);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (par == 1) exp_bits.push_back(~^d);
    if (par == 2) exp_bits.push_back(^d);
    for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);
    exp_busy.push_back(DIV * (9 + ((par != 0) ? 1 : 0) + stops));
  endtask

  task automatic settle();
    txd_start = 1'b0;
    repeat (150) @(negedge clk);
    exp_bits.delete();
    got_bits.delete();
    exp_busy.delete();
    busy_runs.delete();
    frame_start.delete();
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    txd_start = 1'b1;
    txd_data  = d;
    @(negedge clk);
    txd_start = 1'b0;
  endtask

  // Called at a negedge; samples each bit of the selected line at its middle clock.
  task automatic capture_frames(input int nframes, input int nbits);
    int waited;
    for (int f = 0; f < nframes; f++) begin
      waited = 0;
      while (cur_txd !== 1'b0 && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      if (cur_txd !== 1'b0) return;
      frame_start.push_back(cyc);
      repeat (DIV / 2 - 1) @(negedge clk);
      for (int b = 0; b < nbits; b++) begin
        got_bits.push_back(cur_txd);
        if (b != nbits - 1) repeat (DIV) @(negedge clk);
      end
    end
  endtask

  task automatic wait_busy_runs(input int n);
    int waited;
    waited = 0;
    while (busy_runs.size() < n && waited < 300) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txd[i] !== 1'b1) $display("[TB] FAIL reset_txd[%0d]: got %b, expected 1", i, txd[i]);
      else passed++;
      checks++;
      if (busy[i] !== 1'b0) $display("[TB] FAIL reset_busy[%0d]: got %b, expected 0", i, busy[i]);
      else passed++;
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 4'hf || busy !== 4'h0) bad++;
    end
    checks++;
    if (bad != 0) $display("[TB] FAIL reset_hold: got %0d active cycles, expected 0", bad);
    else passed++;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_frame(input logic [1:0] inst, input logic [7:0] d, input int par, input string name);
    logic eb, gb;
    int   eb_len, gb_len, idx;
    settle();
    sel = inst;
    push_frame(d, par, 1);
    send_byte(d);
    checks++;
    if (cur_busy !== 1'b1) $display("[TB] FAIL %s accept_busy: got %b, expected 1", name, cur_busy);
    else passed++;
    capture_frames(1, (par != 0) ? 11 : 10);
    wait_busy_runs(1);
    idx = 0;
    while (exp_bits.size() != 0) begin
      eb = exp_bits.pop_front();
      gb = (got_bits.size() != 0) ? got_bits.pop_front() : 1'bx;
      checks++;
      if (gb !== eb) $display("[TB] FAIL %s bit%0d: got %b, expected %b", name, idx, gb, eb);
      else passed++;
      idx++;
    end
    eb_len = exp_busy.pop_front();
    gb_len = (busy_runs.size() != 0) ? busy_runs.pop_front() : -1;
    checks++;
    if (gb_len != eb_len) $display("[TB] FAIL %s busy_len: got %0d, expected %0d", name, gb_len, eb_len);
    else passed++;
  endtask

  task automatic test_collision();
    logic eb, gb;
    int   eb_len, gb_len, idx, low;
    settle();
    sel = 2'd0;
    push_frame(8'h68, 0, 1);
    send_byte(8'h68);
    fork
      capture_frames(1, 10);
      begin
        repeat (29) @(negedge clk);
        txd_start = 1'b1;
        txd_data  = 8'h55;
        @(negedge clk);
        txd_start = 1'b0;
      end
    join
    low = 0;
    repeat (150) begin
      @(negedge clk);
      if (cur_txd !== 1'b1) low++;
    end
    idx = 0;
    while (exp_bits.size() != 0) begin
      eb = exp_bits.pop_front();
      gb = (got_bits.size() != 0) ? got_bits.pop_front() : 1'bx;
      checks++;
      if (gb !== eb) $display("[TB] FAIL collision bit%0d: got %b, expected %b", idx, gb, eb);
      else passed++;
      idx++;
    end
    checks++;
    if (low != 0) $display("[TB] FAIL collision_quiet: got %0d low cycles after frame, expected 0", low);
    else passed++;
    eb_len = exp_busy.pop_front();
    gb_len = (busy_runs.size() != 0) ? busy_runs.pop_front() : -1;
    checks++;
    if (gb_len != eb_len || busy_runs.size() != 0)
      $display("[TB] FAIL collision_busy: got %0d (extra runs %0d), expected %0d (extra 0)",
               gb_len, busy_runs.size(), eb_len);
    else passed++;
  endtask

  task automatic test_back_to_back(input logic [1:0] inst, input int par, input int stops);
    logic eb, gb;
    int   eb_len, gb_len, idx, frame_len, gap;
    int   nbits;
    settle();
    sel = inst;
    nbits = 9 + ((par != 0) ? 1 : 0) + stops;
    frame_len = DIV * nbits;
    push_frame(8'h68, par, stops);
    push_frame(8'h65, par, stops);
    fork
      begin
        int w;
        @(negedge clk);
        txd_start = 1'b1;
        txd_data  = 8'h68;
        w = 0;
        while (cur_busy !== 1'b1 && w < 300) begin @(negedge clk); w++; end
        txd_data = 8'h65;
        w = 0;
        while (cur_busy !== 1'b0 && w < 300) begin @(negedge clk); w++; end
        w = 0;
        while (cur_busy !== 1'b1 && w < 300) begin @(negedge clk); w++; end
        txd_start = 1'b0;
      end
      capture_frames(2, nbits);
    join
    wait_busy_runs(2);
    idx = 0;
    while (exp_bits.size() != 0) begin
      eb = exp_bits.pop_front();
      gb = (got_bits.size() != 0) ? got_bits.pop_front() : 1'bx;
      checks++;
      if (gb !== eb) $display("[TB] FAIL b2b_s%0d bit%0d: got %b, expected %b", stops, idx, gb, eb);
      else passed++;
      idx++;
    end
    while (exp_busy.size() != 0) begin
      eb_len = exp_busy.pop_front();
      gb_len = (busy_runs.size() != 0) ? busy_runs.pop_front() : -1;
      checks++;
      if (gb_len != eb_len) $display("[TB] FAIL b2b_s%0d busy_len: got %0d, expected %0d", stops, gb_len, eb_len);
      else passed++;
    end
    gap = (frame_start.size() == 2) ? frame_start[1] - frame_start[0] : -1;
    checks++;
    if (gap != frame_len + 1)
      $display("[TB] FAIL b2b_s%0d start_spacing: got %0d clk, expected %0d clk", stops, gap, frame_len + 1);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    settle();
    sel = 2'd0;
    send_byte(8'h68);
    repeat (44) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (cur_txd !== 1'b1) $display("[TB] FAIL midreset_txd: got %b, expected 1", cur_txd);
    else passed++;
    checks++;
    if (cur_busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b, expected 0", cur_busy);
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cur_txd !== 1'b1 || cur_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("[TB] FAIL midreset_no_resume: got %0d active cycles, expected 0", bad);
    else passed++;
    test_frame(2'd0, 8'h68, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_frame(2'd0, 8'h68, 0, "8n1_0x68");
    test_frame(2'd1, 8'h68, 2, "even_0x68");
    test_frame(2'd2, 8'h68, 1, "odd_0x68");
    test_frame(2'd0, 8'hA5, 0, "8n1_0xa5");
    test_collision();
    test_back_to_back(2'd0, 0, 1);
    test_back_to_back(2'd3, 0, 2);
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
